// File: rtl/spectrum_peak_finder.sv
// spectrum_peak_finder: single-pass top-K peak search over one magnitude frame.
// Define SPF_LOCAL_MAX_EN to restrict candidates to local maxima.
module spectrum_peak_finder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int NUM_PEAKS = 3,
  parameter int SKIP_BINS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_W-1:0]             thresh,
  input  logic [DATA_W-1:0]             mag_data,
  input  logic                          mag_valid,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_PEAKS*ADDR_W-1:0]   peak_bin,
  output logic [NUM_PEAKS*DATA_W-1:0]   peak_mag,
  output logic [3:0]                    peak_cnt,
  output logic [DATA_W-1:0]             mean_mag
);

  localparam int ACC_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] SKIP =
    ADDR_W'(SKIP_BINS);
`ifdef SPF_LOCAL_MAX_EN
  localparam logic FLUSH_LAST = 1'b1;
`else
  localparam logic FLUSH_LAST = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] bin_cnt;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] thr_q;
  logic              fcnt;

  logic              cand_v;
  logic [DATA_W-1:0] cand_mag;
  logic [ADDR_W-1:0] cand_bin;

`ifdef SPF_LOCAL_MAX_EN
  logic              cur_v;
  logic [DATA_W-1:0] cur_mag;
  logic [ADDR_W-1:0] cur_bin;
  logic [DATA_W-1:0] prv_mag;
`endif

  logic [DATA_W-1:0]    s_mag   [NUM_PEAKS];
  logic [ADDR_W-1:0]    s_bin   [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] s_ok;
  logic [DATA_W-1:0]    s_mag_d [NUM_PEAKS];
  logic [ADDR_W-1:0]    s_bin_d [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] s_ok_d;
  logic [NUM_PEAKS-1:0] gt;
  logic [3:0]           cnt_d;

  logic beat;
  logic last_beat;
  logic flush_end;

  assign beat      = (state_q == CAPTURE)
                   && mag_valid;
  assign last_beat = beat && (bin_cnt == '1);
  assign flush_end = (state_q == FLUSH)
                   && (fcnt == FLUSH_LAST);

  assign busy = (state_q == CAPTURE)
             || (state_q == FLUSH);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = CAPTURE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        CAPTURE: if (last_beat) state_d = FLUSH;
        FLUSH:   if (flush_end) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Slots stay sorted, so gt[] is a thermometer code.
  always_comb begin
    gt      = '0;
    s_mag_d = s_mag;
    s_bin_d = s_bin;
    s_ok_d  = s_ok;
    cnt_d   = '0;
    for (int k = 0; k < NUM_PEAKS; k++)
      gt[k] = cand_v && (cand_mag > s_mag[k]);
    if (gt[0]) begin
      s_mag_d[0] = cand_mag;
      s_bin_d[0] = cand_bin;
      s_ok_d[0]  = 1'b1;
    end
    for (int k = 1; k < NUM_PEAKS; k++) begin
      if (gt[k-1]) begin
        s_mag_d[k] = s_mag[k-1];
        s_bin_d[k] = s_bin[k-1];
        s_ok_d[k]  = s_ok[k-1];
      end else if (gt[k]) begin
        s_mag_d[k] = cand_mag;
        s_bin_d[k] = cand_bin;
        s_ok_d[k]  = 1'b1;
      end
    end
    for (int k = 0; k < NUM_PEAKS; k++)
      cnt_d = cnt_d + 4'(s_ok_d[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt  <= '0;
      acc      <= '0;
      thr_q    <= '0;
      fcnt     <= 1'b0;
      cand_v   <= 1'b0;
      cand_mag <= '0;
      cand_bin <= '0;
`ifdef SPF_LOCAL_MAX_EN
      cur_v    <= 1'b0;
      cur_mag  <= '0;
      cur_bin  <= '0;
      prv_mag  <= '0;
`endif
      s_ok     <= '0;
      for (int k = 0; k < NUM_PEAKS; k++) begin
        s_mag[k] <= '0;
        s_bin[k] <= '0;
      end
      peak_bin <= '0;
      peak_mag <= '0;
      peak_cnt <= '0;
      mean_mag <= '0;
    end else if (start) begin
      bin_cnt  <= '0;
      acc      <= '0;
      thr_q    <= thresh;
      fcnt     <= 1'b0;
      cand_v   <= 1'b0;
      cand_mag <= '0;
      cand_bin <= '0;
`ifdef SPF_LOCAL_MAX_EN
      cur_v    <= 1'b0;
      cur_mag  <= '0;
      cur_bin  <= '0;
      prv_mag  <= '0;
`endif
      s_ok     <= '0;
      for (int k = 0; k < NUM_PEAKS; k++) begin
        s_mag[k] <= '0;
        s_bin[k] <= '0;
      end
    end else begin
      if (beat) begin
        bin_cnt <= bin_cnt + 1'b1;
        acc     <= acc + ACC_W'(mag_data);
      end
      if (state_q == FLUSH) fcnt <= fcnt + 1'b1;
      else                  fcnt <= 1'b0;
`ifdef SPF_LOCAL_MAX_EN
      // Judge the held bin once its right neighbour is known.
      if (beat) begin
        cand_v   <= cur_v
                 && (cur_bin >= SKIP)
                 && (cur_mag > thr_q)
                 && (cur_mag > prv_mag)
                 && (cur_mag >= mag_data);
        cand_mag <= cur_mag;
        cand_bin <= cur_bin;
        prv_mag  <= cur_mag;
        cur_mag  <= mag_data;
        cur_bin  <= bin_cnt;
        cur_v    <= 1'b1;
      end else if ((state_q == FLUSH) && cur_v) begin
        cand_v   <= (cur_bin >= SKIP)
                 && (cur_mag > thr_q)
                 && (cur_mag > prv_mag);
        cand_mag <= cur_mag;
        cand_bin <= cur_bin;
        cur_v    <= 1'b0;
      end else begin
        cand_v   <= 1'b0;
      end
`else
      cand_v   <= beat
               && (bin_cnt >= SKIP)
               && (mag_data > thr_q);
      cand_mag <= mag_data;
      cand_bin <= bin_cnt;
`endif
      s_ok <= s_ok_d;
      for (int k = 0; k < NUM_PEAKS; k++) begin
        s_mag[k] <= s_mag_d[k];
        s_bin[k] <= s_bin_d[k];
      end
      if (flush_end) begin
        for (int k = 0; k < NUM_PEAKS; k++) begin
          peak_bin[k*ADDR_W +: ADDR_W] <= s_bin_d[k];
          peak_mag[k*DATA_W +: DATA_W] <= s_mag_d[k];
        end
        peak_cnt <= cnt_d;
        mean_mag <= acc[ACC_W-1:ADDR_W];
      end
    end
  end

endmodule
